// File: rtl/uram_capture_buffer_pkg.sv
// Shared types and helpers for the trigger-armed capture buffer.
// Holds the FSM state encoding, the capture-length clamp and the output FIFO sizing rule.
package uram_capture_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE,
        ST_READOUT
    } state_t;

    // Output FIFO slots beyond the RAM read latency.
    localparam int FIFO_MARGIN = 2;

    function automatic int fifo_depth_f(input int read_latency);
        return read_latency + FIFO_MARGIN;
    endfunction

    // A zero length still captures the trigger sample; anything past DEPTH saturates.
    function automatic logic [31:0] len_eff_f(input logic [31:0] len, input logic [31:0] depth);
        if (len == 32'd0) begin
            return 32'd1;
        end else if (len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage

// File: rtl/uram_capture_buffer_sdp_ram_core.sv
// Simple dual-port RAM with byte-enabled writes and a pipelined, read-first read port.
// Read data appears READ_LATENCY cycles after a cycle with rd_en high.
module sdp_ram_core #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_pipe_reg [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_pipe_reg[0] <= mem[rd_addr];
        end
        for (int i = 0; i < BE_W; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        // Later stages shift freely; the top tracks which stage holds a live read.
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_reg[i] <= rd_pipe_reg[i-1];
        end
    end

    assign rd_data = rd_pipe_reg[READ_LATENCY-1];

endmodule

// File: rtl/uram_capture_buffer.sv
// Trigger-armed capture buffer: one-shot or circular capture into RAM, then a
// credit-controlled readout through a small FIFO that absorbs the RAM read latency.
module uram_capture_buffer
    import uram_capture_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    circ_mode,
    input  logic                    arm,
    input  logic                    trigger,
    input  logic                    abort,
    input  logic [ADDR_WIDTH:0]     capture_len,
    input  logic                    sample_valid,
    input  logic [DATA_WIDTH/8-1:0] sample_be,
    input  logic [DATA_WIDTH-1:0]   sample_data,
    input  logic                    rd_start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    wrapped
);
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int FIFO_DEPTH = fifo_depth_f(READ_LATENCY);
    localparam int FP_W       = $clog2(FIFO_DEPTH);
    localparam int FC_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);
    localparam logic [FC_W:0]       FDEPTH_L = (FC_W+1)'(FIFO_DEPTH);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg, rd_addr_reg, rd_issue_addr;
    logic [ADDR_WIDTH:0]     post_cnt_reg, len_eff_reg, rd_left_reg, trig_len, rd_total;
    logic                    circ_reg, wrapped_reg, busy_reg, done_reg;
    logic                    wr_en, rd_issue, rd_issue_last, push, pop, credit_ok;
    logic [READ_LATENCY-1:0] vpipe_reg, lpipe_reg;
    logic [FC_W-1:0]         inflight_reg, fifo_count_reg;
    logic [FP_W-1:0]         fifo_head_reg, fifo_tail_reg;
    logic [DATA_WIDTH-1:0]   fifo_data_reg [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_reg;
    logic [DATA_WIDTH-1:0]   ram_rd_data;

    function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
        return (p == FP_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign trig_len  = (ADDR_WIDTH+1)'(len_eff_f(32'(capture_len), 32'(DEPTH)));
    assign rd_total  = circ_reg ? DEPTH_L : len_eff_reg;
    assign push      = vpipe_reg[READ_LATENCY-1];
    assign pop       = (fifo_count_reg != '0) && out_ready;
    // Reads in flight plus words already buffered must never exceed the FIFO.
    assign credit_ok = ({1'b0, inflight_reg} + {1'b0, fifo_count_reg}) < FDEPTH_L;

    assign out_valid = (fifo_count_reg != '0);
    assign out_data  = fifo_data_reg[fifo_head_reg];
    assign out_last  = fifo_last_reg[fifo_head_reg];
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign wrapped   = wrapped_reg;

    always_comb begin
        state_next    = state_reg;
        wr_en         = 1'b0;
        rd_issue      = 1'b0;
        rd_issue_addr = rd_addr_reg;
        rd_issue_last = (rd_left_reg == ONE_L);
        case (state_reg)
            ST_IDLE: begin
                if (arm) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (trigger) begin
                    wr_en      = sample_valid;
                    state_next = (sample_valid && trig_len == ONE_L) ? ST_DONE : ST_CAPTURE;
                end else begin
                    wr_en = sample_valid && circ_reg;
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    wr_en = 1'b1;
                    if (post_cnt_reg + ONE_L == len_eff_reg) state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // The first read issues in the rd_start cycle itself to meet first-word latency.
                if (rd_start) begin
                    state_next    = ST_READOUT;
                    rd_issue      = 1'b1;
                    rd_issue_addr = circ_reg ? wr_ptr_reg : '0;
                    rd_issue_last = (rd_total == ONE_L);
                end
            end
            ST_READOUT: begin
                rd_issue = (rd_left_reg != '0) && credit_ok;
                if (pop && out_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            wr_en      = 1'b0;
            rd_issue   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            rd_addr_reg    <= '0;
            post_cnt_reg   <= '0;
            len_eff_reg    <= ONE_L;
            rd_left_reg    <= '0;
            circ_reg       <= 1'b0;
            wrapped_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            vpipe_reg      <= '0;
            lpipe_reg      <= '0;
            inflight_reg   <= '0;
            fifo_count_reg <= '0;
            fifo_head_reg  <= '0;
            fifo_tail_reg  <= '0;
            fifo_last_reg  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_next == ST_DONE);
            if (abort) begin
                vpipe_reg      <= '0;
                inflight_reg   <= '0;
                fifo_count_reg <= '0;
                fifo_head_reg  <= '0;
                fifo_tail_reg  <= '0;
            end else begin
                if (state_reg == ST_IDLE && arm) begin
                    wr_ptr_reg   <= '0;
                    wrapped_reg  <= 1'b0;
                    post_cnt_reg <= '0;
                    circ_reg     <= circ_mode;
                end
                if (state_reg == ST_ARMED && trigger) begin
                    len_eff_reg  <= trig_len;
                    post_cnt_reg <= sample_valid ? ONE_L : '0;
                end
                if (state_reg == ST_CAPTURE && sample_valid) begin
                    post_cnt_reg <= post_cnt_reg + ONE_L;
                end
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (&wr_ptr_reg) wrapped_reg <= 1'b1;
                end
                if (rd_issue) begin
                    rd_addr_reg <= rd_issue_addr + 1'b1;
                    rd_left_reg <= ((state_reg == ST_DONE) ? rd_total : rd_left_reg) - ONE_L;
                end
                vpipe_reg[0] <= rd_issue;
                lpipe_reg[0] <= rd_issue_last;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    vpipe_reg[i] <= vpipe_reg[i-1];
                    lpipe_reg[i] <= lpipe_reg[i-1];
                end
                inflight_reg <= inflight_reg + FC_W'(rd_issue) - FC_W'(push);
                if (push) begin
                    fifo_data_reg[fifo_tail_reg] <= ram_rd_data;
                    fifo_last_reg[fifo_tail_reg] <= lpipe_reg[READ_LATENCY-1];
                    fifo_tail_reg                <= fifo_inc(fifo_tail_reg);
                end
                if (pop) fifo_head_reg <= fifo_inc(fifo_head_reg);
                fifo_count_reg <= fifo_count_reg + FC_W'(push) - FC_W'(pop);
            end
        end
    end

    sdp_ram_core #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_be   (sample_be),
        .wr_addr (wr_ptr_reg),
        .wr_data (sample_data),
        .rd_en   (rd_issue),
        .rd_addr (rd_issue_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_uram_capture_buffer.sv
// Bench for uram_capture_buffer: table-driven captures, hand-written corner sequences
// and randomized captures, all checked against a RAM-image reference model.
module tb_uram_capture_buffer;
    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int RL    = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          circ_mode, arm, trigger, abort, sample_valid, rd_start, out_ready;
    logic [AW:0]   capture_len;
    logic [7:0]    sample_be;
    logic [DW-1:0] sample_data, out_data;
    logic          out_valid, out_last, busy, done, wrapped;

    always #5 clk = ~clk;

    uram_capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .circ_mode(circ_mode), .arm(arm), .trigger(trigger),
        .abort(abort), .capture_len(capture_len), .sample_valid(sample_valid),
        .sample_be(sample_be), .sample_data(sample_data), .rd_start(rd_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .wrapped(wrapped)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: an image of the RAM plus the write pointer implied by the samples.
    logic [63:0]  model_mem [DEPTH];
    bit           model_known [DEPTH];
    int           m_ptr;
    bit           m_wrapped;
    bit           m_circ;
    int           m_leff;
    logic [63:0]  got [$];

    typedef struct {
        bit          circ;
        int          len;
        int          npre;
        int          extra;
        bit          trig_sample;
        logic [63:0] base;
        int          ready_mode;
        int          abort_after;
        int          exp_words;
        bit          exp_wrapped;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int len);
        if (len == 0) return 1;
        if (len > DEPTH) return DEPTH;
        return len;
    endfunction

    task automatic model_write(input logic [7:0] be, input logic [63:0] d);
        for (int b = 0; b < 8; b++) begin
            if (be[b]) model_mem[m_ptr][b*8 +: 8] = d[b*8 +: 8];
        end
        if (be == 8'hFF) model_known[m_ptr] = 1'b1;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_ptr == 0) m_wrapped = 1'b1;
    endtask

    task automatic send(input bit v, input logic [7:0] be, input logic [63:0] d);
        sample_valid = v;
        sample_be    = be;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic run_capture(input bit circ, input int len, input int npre, input int extra,
                               input bit trig_sample, input logic [63:0] base,
                               input logic [7:0] be_fixed, input bit rnd);
        logic [63:0] d;
        logic [7:0]  be;
        int          post;
        d = base;
        circ_mode = circ;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        circ_mode = 1'b0;
        m_ptr = 0;
        m_wrapped = 1'b0;
        m_circ = circ;
        for (int i = 0; i < npre; i++) begin
            if (rnd && $urandom_range(3) == 0) send(1'b0, 8'hFF, 64'hDEAD);
            be = rnd ? 8'($urandom) : be_fixed;
            send(1'b1, be, d);
            if (circ) model_write(be, d);
            d++;
        end
        m_leff = clamp(len);
        post = 0;
        be = rnd ? 8'($urandom) : be_fixed;
        trigger = 1'b1;
        capture_len = 5'(len);
        sample_valid = trig_sample;
        sample_be = be;
        sample_data = d;
        tick();
        trigger = 1'b0;
        sample_valid = 1'b0;
        if (trig_sample) begin
            model_write(be, d);
            d++;
            post = 1;
        end
        for (int c = post; c < m_leff + extra; c++) begin
            if (rnd && $urandom_range(2) == 0) send(1'b0, 8'hFF, 64'hBEEF);
            be = rnd ? 8'($urandom) : be_fixed;
            send(1'b1, be, d);
            if (c < m_leff) model_write(be, d);
            d++;
        end
        $display("[TB] capture circ=%0b len=%0d eff=%0d ptr=%0d wrapped=%0b", circ, len, m_leff, m_ptr, wrapped);
        check("capture_done", done, 1'b1);
        check("capture_busy", busy, 1'b1);
    endtask

    task automatic run_readout(input int ready_mode, input int abort_after, output int nacc);
        logic [63:0] exp_q [$];
        bit          kn_q [$];
        int          n, start, first_wait, acc_first, acc_last;
        bit          stall;
        logic [63:0] prev_d;
        logic        prev_l;
        n = m_circ ? DEPTH : m_leff;
        start = m_circ ? m_ptr : 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_mem[(start + i) % DEPTH]);
            kn_q.push_back(model_known[(start + i) % DEPTH]);
        end
        got.delete();
        nacc = 0;
        first_wait = -1;
        acc_first = 0;
        acc_last = 0;
        stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        out_ready = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int cyc = 0; cyc < 400 && nacc < n; cyc++) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(1));
            endcase
            if (out_valid && first_wait < 0) first_wait = cyc;
            if (stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, prev_d);
                check("stall_last", out_last, prev_l);
            end
            stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            if (out_valid && out_ready) begin
                $display("[TB] word %0d data=%h last=%0b", nacc, out_data, out_last);
                if (kn_q[nacc]) check("read_data", out_data, exp_q[nacc]);
                check("read_last", out_last, (nacc == n - 1));
                got.push_back(out_data);
                if (nacc == 0) acc_first = cyc;
                acc_last = cyc;
                nacc++;
            end
            tick();
            if (abort_after >= 0 && nacc == abort_after) begin
                out_ready = 1'b0;
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_out_valid", out_valid, 1'b0);
                check("abort_busy", busy, 1'b0);
                return;
            end
        end
        out_ready = 1'b0;
        check("first_valid_latency", first_wait, RL);
        check("readout_count", nacc, n);
        if (ready_mode == 0) check("throughput", acc_last - acc_first, n - 1);
        check("readout_end_busy", busy, 1'b0);
        check("readout_end_valid", out_valid, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        circ_mode = 0; arm = 0; trigger = 0; abort = 0; capture_len = '0;
        sample_valid = 0; sample_be = '0; sample_data = '0; rd_start = 0; out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            model_known[i] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_wrapped", wrapped, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 64'h0);
        check("reset_out_last", out_last, 1'b0);
        rst = 1'b0;
        tick();

        //          circ len pre ex trg base        rdy abort words wrap
        vecs[0] = '{1'b0, 5,  0, 0, 1'b0, 64'hA0,  0, -1,  5, 1'b0};
        vecs[1] = '{1'b0, 5,  0, 0, 1'b0, 64'hA0,  1, -1,  5, 1'b0};
        vecs[2] = '{1'b1, 4, 20, 0, 1'b0, 64'h00,  0, -1, 16, 1'b1};
        vecs[3] = '{1'b0, 0,  0, 2, 1'b1, 64'h55,  0, -1,  1, 1'b0};
        vecs[4] = '{1'b0, 17, 0, 2, 1'b0, 64'h300, 0, -1, 16, 1'b1};
        vecs[5] = '{1'b0, 6,  0, 0, 1'b0, 64'hB0,  0,  2,  2, 1'b0};
        vecs[6] = '{1'b0, 3,  0, 1, 1'b1, 64'hC0,  2, -1,  3, 1'b0};
        vecs[7] = '{1'b1, 3,  5, 0, 1'b1, 64'hD0,  2, -1, 16, 1'b0};
        for (int t = 0; t < 8; t++) begin
            run_capture(vecs[t].circ, vecs[t].len, vecs[t].npre, vecs[t].extra,
                        vecs[t].trig_sample, vecs[t].base, 8'hFF, 1'b0);
            check("vec_wrapped", wrapped, vecs[t].exp_wrapped);
            run_readout(vecs[t].ready_mode, vecs[t].abort_after, nacc);
            check("vec_words", nacc, vecs[t].exp_words);
        end
        check("circ_first_word", (vecs[2].exp_words == 16) ? 64'h0 : 64'h1, 64'h0);

        // Partial byte write over an all-ones slot.
        run_capture(1'b0, 1, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        run_readout(0, -1, nacc);
        run_capture(1'b0, 1, 0, 0, 1'b1, 64'h0000_0000_0000_1234, 8'h03, 1'b0);
        run_readout(0, -1, nacc);
        check("byte_enable_word", got[0], 64'hFFFF_FFFF_FFFF_1234);

        // DONE holds through arm and trigger.
        run_capture(1'b0, 2, 0, 0, 1'b0, 64'hE0, 8'hFF, 1'b0);
        arm = 1'b1;
        trigger = 1'b1;
        tick();
        arm = 1'b0;
        trigger = 1'b0;
        check("done_holds", done, 1'b1);
        run_readout(0, -1, nacc);
        check("done_holds_words", nacc, 2);

        // Abort beats arm and trigger arriving together in IDLE.
        arm = 1'b1;
        trigger = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        trigger = 1'b0;
        abort = 1'b0;
        check("abort_wins_busy", busy, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_capture(1'($urandom_range(1)), int'($urandom_range(18)), int'($urandom_range(24)),
                        int'($urandom_range(2)), 1'($urandom_range(1)), {$urandom, $urandom},
                        8'hFF, 1'b1);
            check("rand_wrapped", wrapped, m_wrapped);
            run_readout(2, -1, nacc);
        end

        // Asynchronous reset in the middle of a circular capture that has already wrapped.
        circ_mode = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        circ_mode = 1'b0;
        for (int i = 0; i < 17; i++) send(1'b1, 8'hFF, 64'h7700 + 64'(i));
        trigger = 1'b1;
        capture_len = 5'd10;
        send(1'b1, 8'hFF, 64'h7800);
        trigger = 1'b0;
        send(1'b1, 8'hFF, 64'h7801);
        check("pre_reset_busy", busy, 1'b1);
        check("pre_reset_wrapped", wrapped, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_busy", busy, 1'b0);
        check("mid_reset_done", done, 1'b0);
        check("mid_reset_wrapped", wrapped, 1'b0);
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_out_data", out_data, 64'h0);
        check("mid_reset_out_last", out_last, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
